sound_stream_player: RTL
========================

Name: sound_stream_player

Overview:
- Single-clock, parametrised successor to the sound FIFO playout block.
- Accepts N-channel PCM frames from the host/stream side into an internal synchronous FIFO.
- Holds playback until a programmable prefill level is reached and a frame-start pulse arrives, then emits one frame every cfg_clocks_per_sample clocks.
- Tracks underruns and drops an equal number of later input frames so latency does not accumulate; counts overflows; supports mono-to-all-channel replication.

Parameters:
NUM_CH, 2, channel count carried per frame (1..8)
SW, 16, sample width in bits
DEPTH_LOG2, 12, FIFO depth = 2**DEPTH_LOG2 frames
HOLD_LAST, 1, 1 = repeat last frame on underrun; 0 = output zero

Ports:
clk_sys  in  1  system clock; all logic on rising edge
sound_reset_n  in  1  asynchronous active-low reset
sound_enabled  in  1  playback enable; 0 = freeze tick counter, outputs hold
sound_synced  in  1  1 = underruns are not counted as debt (host is paced externally)
frame_start  in  1  single-cycle pulse at video frame boundary; used for start alignment
cfg_chan  in  4  active channels: 0 = silent, 1 = mono (ch0 replicated), 2..NUM_CH = direct
cfg_clocks_per_sample  in  16  clocks between output frames; values <2 are treated as 2
cfg_prefill  in  DEPTH_LOG2+1  FIFO level required before arming
sound_write  in  1  input frame valid
sound_in  in  NUM_CH*SW  input frame, ch0 in LSBs
sound_write_ready  out  1  FIFO not full
sound_out  out  NUM_CH*SW  current output frame
sample_strobe  out  1  one-cycle pulse when sound_out updates
fifo_level  out  DEPTH_LOG2+1  frames stored
underrun_count  out  16  saturating count of empty ticks
overflow_count  out  16  saturating count of writes seen while full
playing  out  1  state == PLAY

Behaviour:
- Reset (async assert, sync release): FIFO empty; state IDLE; sound_out 0; sample_strobe 0; counters 0; debt 0; tick divider 0; sound_write_ready 1.
- Write accept: sound_write && sound_write_ready. If debt>0, frame is dropped and debt decrements. Otherwise frame is pushed.
- cfg_chan==0: writes accepted and discarded; sound_out forced 0.
- Write while full: no push; overflow_count++ (saturates at FFFF).
- States:
  - IDLE -> PREFILL when sound_enabled.
  - PREFILL -> ARMED when fifo_level >= cfg_prefill (cfg_prefill 0 passes immediately).
  - ARMED -> PLAY on frame_start. frame_start in the same cycle as PREFILL->ARMED does not count.
  - PLAY -> IDLE when sound_enabled falls; FIFO contents retained, debt cleared.
- Divider runs only in PLAY. Tick fires when the count reaches cpc-1, then wraps to 0. The first tick occurs cpc clocks after entering PLAY.
- On tick with FIFO non-empty: pop. sound_out updates one cycle later with sample_strobe=1.
  - Mono: ch0 copied to every lane.
  - cfg_chan < NUM_CH: lanes >= cfg_chan output 0.
- On tick with FIFO empty: sample_strobe=1 one cycle later; sound_out holds (HOLD_LAST=1) or becomes 0 (HOLD_LAST=0). underrun_count++ (saturating). If !sound_synced, debt++ (saturating).
- Simultaneous underrun and dropped write in one cycle: debt unchanged.
- Simultaneous push and pop: fifo_level unchanged. Pop and push on full are legal; ready reflects the pre-edge level.
- cfg_clocks_per_sample changes take effect at the next wrap. cfg_chan changes take effect at the next tick.
- Mid-operation reset: immediate return to reset values; partially written frame lost.

Test Plan:
- Prefill/start: cfg_prefill=4, cpc=10. Write 4 frames, pulse frame_start -> playing=1. First sample_strobe 11 clocks after PLAY entry, then every 10 clocks; outputs match FIFO order.
- Underrun debt: sound_synced=0, HOLD_LAST=1. Drain the FIFO and let 3 ticks pass empty -> underrun_count=3; sound_out holds the last frame. Next 3 writes are dropped (fifo_level stays 0); the 4th is stored.
- Synced mode: same as the underrun-debt scenario with sound_synced=1 -> underrun_count=3, no writes dropped.
- Overflow: DEPTH_LOG2=2, not playing. Write 6 frames -> fifo_level=4, sound_write_ready=0 after the 4th accept, overflow_count=2.
- Mono/partial: NUM_CH=4. cfg_chan=1 with ch0=16'h1234 -> all lanes 1234. cfg_chan=2 -> lanes 2,3 = 0.
- Reset mid-play: assert sound_reset_n low during PLAY -> same cycle: sound_out=0, fifo_level=0, playing=0. After release, re-prefill is required.

Source files
------------

// File: rtl/sound_stream_player.sv
// Sound stream player: buffers N-channel PCM frames in a synchronous FIFO and
// plays them out at a programmable rate once prefilled and frame-aligned.
module sound_stream_player #(
    parameter int NUM_CH     = 2,
    parameter int SW         = 16,
    parameter int DEPTH_LOG2 = 12,
    parameter int HOLD_LAST  = 1
) (
    input  logic                   clk_sys,
    input  logic                   sound_reset_n,
    input  logic                   sound_enabled,
    input  logic                   sound_synced,
    input  logic                   frame_start,
    input  logic [3:0]             cfg_chan,
    input  logic [15:0]            cfg_clocks_per_sample,
    input  logic [DEPTH_LOG2:0]    cfg_prefill,
    input  logic                   sound_write,
    input  logic [NUM_CH*SW-1:0]   sound_in,
    output logic                   sound_write_ready,
    output logic [NUM_CH*SW-1:0]   sound_out,
    output logic                   sample_strobe,
    output logic [DEPTH_LOG2:0]    fifo_level,
    output logic [15:0]            underrun_count,
    output logic [15:0]            overflow_count,
    output logic                   playing
);

    localparam int FW    = NUM_CH * SW;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_ARMED, S_PLAY} state_t;

    state_t                 state, state_nxt;
    logic [FW-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic [15:0]            debt, div_cnt, cpc_cur, cpc_cfg;
    logic                   full, empty, tick, wr_accept, push, pop, drop, underrun, debt_inc;
    logic                   pend_valid, pend_pop;
    logic [3:0]             pend_chan;
    logic [FW-1:0]          pend_data, fmt, out_q;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign cpc_cfg  = (cfg_clocks_per_sample < 16'd2) ? 16'd2 : cfg_clocks_per_sample;
    assign tick     = (state == S_PLAY) && (div_cnt == cpc_cur - 16'd1);

    assign wr_accept = sound_write && !full;
    assign drop      = wr_accept && (debt != 16'd0);
    assign push      = wr_accept && (debt == 16'd0) && (cfg_chan != 4'd0);
    assign pop       = tick && !empty;
    assign underrun  = tick && empty;
    assign debt_inc  = underrun && !sound_synced;

    assign sound_write_ready = !full;
    assign sound_out         = out_q;
    assign fifo_level        = level;
    assign playing           = (state == S_PLAY);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (sound_enabled) state_nxt = S_PREFILL;
            S_PREFILL: if (!sound_enabled) state_nxt = S_IDLE;
                       else if (level >= cfg_prefill) state_nxt = S_ARMED;
            S_ARMED:   if (!sound_enabled) state_nxt = S_IDLE;
                       else if (frame_start) state_nxt = S_PLAY;
            S_PLAY:    if (!sound_enabled) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Lane shaping: mono replicates ch0, otherwise lanes at or above cfg_chan are silenced.
    always_comb begin
        fmt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_chan == 4'd1)
                fmt[i*SW +: SW] = pend_data[SW-1:0];
            else if (i < int'(pend_chan))
                fmt[i*SW +: SW] = pend_data[i*SW +: SW];
        end
    end

    // NOTE: the frame storage carries no reset; pend_data is only consumed when pend_pop is set.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= sound_in;
        if (pop)  pend_data   <= mem[rd_ptr];
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge sound_reset_n) begin
        if (!sound_reset_n) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            debt           <= '0;
            div_cnt        <= '0;
            cpc_cur        <= 16'd2;
            underrun_count <= '0;
            overflow_count <= '0;
            pend_valid     <= 1'b0;
            pend_pop       <= 1'b0;
            pend_chan      <= '0;
            out_q          <= '0;
            sample_strobe  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (sound_write && full && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
            if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;

            // Debt pays back underruns by dropping later input frames; cleared when playback stops.
            if (state == S_PLAY && !sound_enabled)
                debt <= '0;
            else if (debt_inc && !drop && debt != 16'hFFFF)
                debt <= debt + 16'd1;
            else if (drop && !debt_inc)
                debt <= debt - 16'd1;

            // Period is re-sampled only at a wrap so a running sample interval is never stretched.
            if (state != S_PLAY) begin
                div_cnt <= '0;
                cpc_cur <= cpc_cfg;
            end else if (tick) begin
                div_cnt <= '0;
                cpc_cur <= cpc_cfg;
            end else if (sound_enabled) begin
                div_cnt <= div_cnt + 16'd1;
            end

            pend_valid <= tick;
            pend_pop   <= pop;
            if (tick) pend_chan <= cfg_chan;

            sample_strobe <= pend_valid;
            if (pend_valid) begin
                if (pend_pop)
                    out_q <= fmt;
                else if (HOLD_LAST == 0)
                    out_q <= '0;
            end
        end
    end

endmodule
